// File: rtl/scene_controller.sv
// Frame-synchronous scene sequencer: picks the per-frame scene and moves the character
// sprite only during vertical blanking so the visible image never tears.
module scene_controller #(
   parameter int H_ACTIVE   = 640,
   parameter int V_ACTIVE   = 480,
   parameter int SPRITE_W   = 64,
   parameter int SPRITE_H   = 64,
   parameter int X_INIT     = 152,
   parameter int Y_INIT     = 40,
   parameter int STEP       = 2,
   parameter int WIN_FRAMES = 120
) (
   input  logic       FPGA_Clock,
   input  logic       FPGA_Reset_N,
   input  logic [9:0] h_count,
   input  logic [9:0] v_count,
   input  logic       Start_Btn,
   input  logic       timeUP,
   input  logic       win_event,
   output logic [9:0] X_POS_Sprite,
   output logic [9:0] Y_POS_Sprite,
   output logic [1:0] scene_sel,
   output logic       show_sprite,
   output logic       frame_tick,
   output logic [1:0] state
);

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_PLAY  = 2'b01;
   localparam logic [1:0] ST_WIN   = 2'b10;
   localparam logic [1:0] ST_SLEEP = 2'b11;

   localparam int CW = (WIN_FRAMES > 1) ? $clog2(WIN_FRAMES) : 1;
   localparam logic signed [10:0] X_MAX  = 11'(H_ACTIVE - SPRITE_W);
   localparam logic signed [10:0] Y_MAX  = 11'(V_ACTIVE - SPRITE_H);
   localparam logic signed [10:0] STEP_S = 11'(STEP);

   logic          btn_s1, btn_s2, btn_s3, start_p;
   logic          cond, cond_q;
   logic          dir_x, dir_y, dir_x_d, dir_y_d;
   logic [CW-1:0] win_cnt, win_cnt_d;
   logic [1:0]    state_d;
   logic [9:0]    x_d, y_d;
   logic signed [10:0] nx, ny;

   assign cond = (h_count == 10'd0) && (v_count == 10'(V_ACTIVE));

   // Button sync, edge detect and blanking-start detect; start_p is registered.
   always_ff @(posedge FPGA_Clock or negedge FPGA_Reset_N) begin
      if (!FPGA_Reset_N) begin
         btn_s1     <= 1'b0;
         btn_s2     <= 1'b0;
         btn_s3     <= 1'b0;
         start_p    <= 1'b0;
         cond_q     <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         btn_s1     <= Start_Btn;
         btn_s2     <= btn_s1;
         btn_s3     <= btn_s2;
         start_p    <= btn_s2 & ~btn_s3;
         cond_q     <= cond;
         frame_tick <= cond & ~cond_q;
      end
   end

   // Direction bit 0 means moving toward larger coordinates.
   assign nx = dir_x ? ($signed({1'b0, X_POS_Sprite}) - STEP_S)
                     : ($signed({1'b0, X_POS_Sprite}) + STEP_S);
   assign ny = dir_y ? ($signed({1'b0, Y_POS_Sprite}) - STEP_S)
                     : ($signed({1'b0, Y_POS_Sprite}) + STEP_S);

   always_comb begin
      state_d   = state;
      x_d       = X_POS_Sprite;
      y_d       = Y_POS_Sprite;
      dir_x_d   = dir_x;
      dir_y_d   = dir_y;
      win_cnt_d = win_cnt;
      case (state)
         ST_IDLE: begin
            if (timeUP) begin
               state_d = ST_SLEEP;
            end else if (start_p) begin
               state_d = ST_PLAY;
               x_d     = 10'(X_INIT);
               y_d     = 10'(Y_INIT);
            end
         end
         ST_PLAY: begin
            if (win_event) begin
               state_d   = ST_WIN;
               win_cnt_d = '0;
            end else if (timeUP) begin
               state_d = ST_SLEEP;
            end else if (frame_tick) begin
               if (!dir_x && nx >= X_MAX) begin
                  x_d     = X_MAX[9:0];
                  dir_x_d = 1'b1;
               end else if (dir_x && nx <= 11'sd0) begin
                  x_d     = 10'd0;
                  dir_x_d = 1'b0;
               end else begin
                  x_d = nx[9:0];
               end
               if (!dir_y && ny >= Y_MAX) begin
                  y_d     = Y_MAX[9:0];
                  dir_y_d = 1'b1;
               end else if (dir_y && ny <= 11'sd0) begin
                  y_d     = 10'd0;
                  dir_y_d = 1'b0;
               end else begin
                  y_d = ny[9:0];
               end
            end
         end
         ST_WIN: begin
            if (frame_tick) begin
               if (win_cnt == CW'(WIN_FRAMES - 1)) begin
                  state_d = ST_IDLE;
               end else begin
                  win_cnt_d = win_cnt + 1'b1;
               end
            end
         end
         default: begin
            if (start_p) begin
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge FPGA_Clock or negedge FPGA_Reset_N) begin
      if (!FPGA_Reset_N) begin
         state        <= ST_IDLE;
         scene_sel    <= 2'b00;
         show_sprite  <= 1'b0;
         X_POS_Sprite <= 10'(X_INIT);
         Y_POS_Sprite <= 10'(Y_INIT);
         dir_x        <= 1'b0;
         dir_y        <= 1'b0;
         win_cnt      <= '0;
      end else begin
         state        <= state_d;
         scene_sel    <= state_d;
         show_sprite  <= (state_d == ST_PLAY);
         X_POS_Sprite <= x_d;
         Y_POS_Sprite <= y_d;
         dir_x        <= dir_x_d;
         dir_y        <= dir_y_d;
         win_cnt      <= win_cnt_d;
      end
   end

endmodule

// File: doc/scene_controller.md
Name: scene_controller

Overview:
- Frame-synchronous scene sequencer for the VGA pipeline.
- Decides per frame what the pixel mux shows: gray background, moving character sprite, win sprite or blank/sleep screen.
- Owns the sprite position registers and updates them only during vertical blanking, so there is no tearing.
- Sits between the VGA timing counters, the sleep timer, user input and the sprite/colour muxes.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- SPRITE_W, 64, character sprite width in pixels
- SPRITE_H, 64, character sprite height in pixels
- X_INIT, 152, sprite X after reset or on entering PLAY
- Y_INIT, 40, sprite Y after reset or on entering PLAY
- STEP, 2, pixels moved per frame on each axis
- WIN_FRAMES, 120, number of frames the WIN scene is held

Ports:
- FPGA_Clock  in  1  system clock; the only clock
- FPGA_Reset_N  in  1  asynchronous, active-low reset
- h_count  in  10  horizontal pixel counter from VGA_Controller
- v_count  in  10  vertical line counter from VGA_Controller
- Start_Btn  in  1  asynchronous push-button, active-high
- timeUP  in  1  level from sleep timer, synchronous to FPGA_Clock
- win_event  in  1  synchronous single-cycle pulse
- X_POS_Sprite  out  10  sprite top-left X
- Y_POS_Sprite  out  10  sprite top-left Y
- scene_sel  out  2  mux select: 00 gray, 01 sprite over gray, 10 win sprite, 11 black
- show_sprite  out  1  1 when scene_sel==01
- frame_tick  out  1  one-cycle pulse at the start of vertical blanking
- state  out  2  00 IDLE, 01 PLAY, 10 WIN, 11 SLEEP

Behaviour:
- Reset (asynchronous, FPGA_Reset_N=0):
  - state=IDLE, scene_sel=00, show_sprite=0, frame_tick=0.
  - X_POS_Sprite=X_INIT, Y_POS_Sprite=Y_INIT.
  - Direction bits = +X, +Y; WIN counter=0; synchronizer flops=0.
  - Reset asserted mid-operation aborts any state immediately; no partial update survives.
- Start_Btn path:
  - Two-flop synchronizer, then rising-edge detect giving start_p, one cycle wide.
  - Latency from button edge to start_p: 3 clocks. Holding the button produces only one start_p.
- frame_tick:
  - cond = (h_count==0 && v_count==V_ACTIVE).
  - frame_tick = cond & ~cond_q, registered, so there is exactly one pulse per frame even though the counters hold for several clocks.
- State transitions, evaluated every clock. Priority within a cycle: win_event > timeUP > start_p.
  - IDLE: start_p -> PLAY, and position is reloaded to X_INIT/Y_INIT. timeUP -> SLEEP.
  - PLAY: win_event -> WIN, counter cleared. timeUP -> SLEEP.
  - WIN: counter increments on each frame_tick. When count reaches WIN_FRAMES-1 and a frame_tick occurs -> IDLE. timeUP and start_p are ignored.
  - SLEEP: start_p -> IDLE. The wake-up start_p does not also start PLAY.
  - win_event outside PLAY is ignored.
- Motion (PLAY only, on the cycle frame_tick=1; outputs change the following cycle):
  - nx = X ± STEP, computed in 11 bits signed to avoid wrap.
  - If moving + and nx ≥ H_ACTIVE-SPRITE_W: X = H_ACTIVE-SPRITE_W and direction flips to -.
  - If moving - and nx ≤ 0: X = 0 and direction flips to +.
  - Y uses the same rule with V_ACTIVE and SPRITE_H.
  - Positions never leave [0, H_ACTIVE-SPRITE_W] × [0, V_ACTIVE-SPRITE_H].
- Position freeze: outside PLAY, position holds its value. In WIN it is frozen at the value it had when win_event arrived.
- Scene select by state (registered, updated together with state):
  - IDLE -> 00
  - PLAY -> 01
  - WIN -> 10
  - SLEEP -> 11
- Simultaneous events:
  - frame_tick and win_event in the same cycle in PLAY: go to WIN and skip the move.
  - frame_tick and start_p in IDLE: go to PLAY at X_INIT; the first move happens on the next frame_tick.

Test Plan:
- Reset, then pulse Start_Btn for 10 clocks -> start_p exactly once, 3 clocks after the edge. state=01, scene_sel=01, X=152, Y=40.
- PLAY for 3 frames -> X=158, Y=46. Each update appears 1 clock after frame_tick and never mid-frame.
- Force X=574 (moving +) and run 1 frame -> X=576 with direction flipped. Next frame -> X=574. Same check at the 0 bound with Y.
- win_event in PLAY -> state=10, scene_sel=10, position frozen. After exactly 120 frame_ticks -> state=00, scene_sel=00.
- win_event and timeUP in the same cycle in PLAY -> WIN. timeUP in IDLE -> SLEEP with scene_sel=11. Start_Btn in SLEEP -> IDLE, not PLAY.
- Assert FPGA_Reset_N=0 mid-WIN, asynchronously between clock edges -> all outputs at reset values immediately, without waiting for a clock edge.
